// File: rtl/sprite_palette_engine_pkg.sv
// Shared types, constants and helpers for the sprite palette engine.
// DEFAULT_PALETTE is the image loaded into palette RAM on every reset.
package sprite_palette_pkg;

    typedef logic [11:0] rgb12_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } engine_state_t;

    localparam int unsigned PAL_BANKS   = 4;
    localparam int unsigned PAL_ENTRIES = 16;
    localparam int unsigned PAL_BANK_W  = 2;
    localparam int unsigned PAL_IDX_W   = 4;

    localparam logic [4:0] FADE_MAX = 5'd16;
    localparam rgb12_t     WHITE    = 12'hFFF;

    localparam rgb12_t DEFAULT_PALETTE [PAL_BANKS][PAL_ENTRIES] = '{
        '{12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
          12'h888, 12'h444, 12'hC00, 12'h0C0, 12'h00C, 12'hCC0, 12'h0CC, 12'hC0C},
        '{12'h000, 12'hFDB, 12'hE96, 12'hA63, 12'h731, 12'h420, 12'hFEE, 12'hC88,
          12'h3A2, 12'h7D5, 12'h158, 12'h39C, 12'h6BF, 12'hFE0, 12'hA80, 12'h222},
        '{12'h000, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 12'h999, 12'h777,
          12'h666, 12'h555, 12'h333, 12'h111, 12'hF44, 12'h4F4, 12'h44F, 12'hFC4},
        '{12'h000, 12'hF80, 12'hF40, 12'hF00, 12'hC00, 12'h800, 12'h400, 12'hFF8,
          12'hFF4, 12'h8F8, 12'h48F, 12'h84F, 12'hF8F, 12'h8FF, 12'hFFF, 12'h123}
    };

    function automatic rgb12_t default_entry(input logic [PAL_BANK_W-1:0] bank,
                                             input logic [PAL_IDX_W-1:0]  idx);
        return DEFAULT_PALETTE[bank][idx];
    endfunction

    // (c * lvl) >> 4 keeps bits [7:4] of the 8-bit product; lvl=16 passes c through.
    function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [4:0] lvl);
        return 4'(({4'd0, c} * {3'd0, lvl}) >> 4);
    endfunction

endpackage

// File: rtl/sprite_palette_engine_if.sv
// Pixel, palette-write, effect-control and colour-output signals of the engine.
interface sprite_palette_engine_if
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned NUM_BANKS = 4
);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);

    logic              frame_tick;
    logic              pix_valid;
    logic [BANK_W-1:0] bank_sel;
    logic [IDX_W-1:0]  index;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_index;
    rgb12_t            wr_rgb;
    logic              flash_start;
    logic              fade_start;
    logic              fade_clear;
    logic              init_done;
    logic              fade_busy;
    logic              out_valid;
    logic              pix_transparent;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;

    modport master (
        output frame_tick, pix_valid, bank_sel, index,
        output wr_en, wr_bank, wr_index, wr_rgb,
        output flash_start, fade_start, fade_clear,
        input  init_done, fade_busy, out_valid, pix_transparent, red, green, blue
    );

    modport slave (
        input  frame_tick, pix_valid, bank_sel, index,
        input  wr_en, wr_bank, wr_index, wr_rgb,
        input  flash_start, fade_start, fade_clear,
        output init_done, fade_busy, out_valid, pix_transparent, red, green, blue
    );

endinterface

// File: rtl/sprite_palette_engine_ram.sv
// Simple dual-port palette RAM: one write port, one synchronous read-first read port.
module palette_ram
    import sprite_palette_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rgb12_t        wdata,
    input  logic [AW-1:0] raddr,
    output rgb12_t        rdata
);

    rgb12_t mem [1 << AW];

    // A read of the entry being written this cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_palette_engine.sv
// Multi-bank sprite palette lookup with hit-flash, fade-to-black and transparent key.
// Stage 1 is the palette RAM read, stage 2 applies effects into the output registers.
module sprite_palette_engine
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    sprite_palette_engine_if.slave bus
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned AW     = BANK_W + IDX_W;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned CNT_W  = $clog2(FLASH_FRAMES + 1);

    engine_state_t    state;
    logic [AW-1:0]    init_addr;
    logic [4:0]       level;
    logic             fading;
    logic [CNT_W-1:0] flash_cnt;
    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    rgb12_t           ram_wdata;
    rgb12_t           ram_rdata;

    // The reload owns the write port during INIT; host writes are dropped then.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = init_addr;
        ram_wdata = default_entry(PAL_BANK_W'(init_addr[AW-1:IDX_W]),
                                  PAL_IDX_W'(init_addr[IDX_W-1:0]));
        if (state == ST_INIT) begin
            ram_we = 1'b1;
        end else if (bus.wr_en) begin
            ram_we    = 1'b1;
            ram_waddr = {bus.wr_bank, bus.wr_index};
            ram_wdata = bus.wr_rgb;
        end
    end

    palette_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({bus.bank_sel, bus.index}),
        .rdata (ram_rdata)
    );

    assign bus.fade_busy = (level != 5'd0) && (level != FADE_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state               <= ST_INIT;
            init_addr           <= '0;
            bus.init_done       <= 1'b0;
            level               <= FADE_MAX;
            fading              <= 1'b0;
            flash_cnt           <= '0;
            s1_valid            <= 1'b0;
            s1_idx              <= '0;
            bus.out_valid       <= 1'b0;
            bus.pix_transparent <= 1'b0;
            bus.red             <= '0;
            bus.green           <= '0;
            bus.blue            <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == AW'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    bus.init_done <= 1'b1;
                end
            endcase

            if (bus.fade_clear) begin
                level  <= FADE_MAX;
                fading <= 1'b0;
            end else if (bus.fade_start) begin
                level  <= FADE_MAX;
                fading <= 1'b1;
            end else if (bus.frame_tick && fading && (level != 5'd0)) begin
                level <= level - 1'b1;
            end

            if (bus.flash_start) begin
                flash_cnt <= CNT_W'(FLASH_FRAMES);
            end else if (bus.frame_tick && (flash_cnt != '0)) begin
                flash_cnt <= flash_cnt - 1'b1;
            end

            s1_valid <= bus.pix_valid && (state == ST_RUN);
            s1_idx   <= bus.index;

            bus.out_valid <= s1_valid;
            if (!s1_valid) begin
                bus.pix_transparent             <= 1'b0;
                {bus.red, bus.green, bus.blue}  <= '0;
            end else if (s1_idx == IDX_W'(TRANSPARENT_IDX)) begin
                bus.pix_transparent             <= 1'b1;
                {bus.red, bus.green, bus.blue}  <= '0;
            end else if (flash_cnt[0]) begin
                bus.pix_transparent             <= 1'b0;
                {bus.red, bus.green, bus.blue}  <= WHITE;
            end else begin
                bus.pix_transparent <= 1'b0;
                bus.red             <= fade_chan(ram_rdata[11:8], level);
                bus.green           <= fade_chan(ram_rdata[7:4], level);
                bus.blue            <= fade_chan(ram_rdata[3:0], level);
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed bench for sprite_palette_engine: reload timing, lookups, writes, fade, flash, reset.
module tb_sprite_palette_engine;
    import sprite_palette_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sprite_palette_engine_if #(.IDX_W(4), .NUM_BANKS(4)) bus_if ();

    sprite_palette_engine #(
        .IDX_W           (4),
        .NUM_BANKS       (4),
        .FLASH_FRAMES    (8),
        .TRANSPARENT_IDX (0)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] px_word();
        return {18'd0, bus_if.out_valid, bus_if.pix_transparent,
                bus_if.red, bus_if.green, bus_if.blue};
    endfunction

    function automatic logic [31:0] exp_word(input logic v, input logic t, input rgb12_t c);
        return {18'd0, v, t, c};
    endfunction

    function automatic logic [31:0] flags();
        return {30'd0, bus_if.init_done, bus_if.fade_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ctl(input logic fs, input logic fc, input logic fl, input logic ft);
        bus_if.fade_start  = fs;
        bus_if.fade_clear  = fc;
        bus_if.flash_start = fl;
        bus_if.frame_tick  = ft;
        @(negedge clk);
        bus_if.fade_start  = 1'b0;
        bus_if.fade_clear  = 1'b0;
        bus_if.flash_start = 1'b0;
        bus_if.frame_tick  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) ctl(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic write_px(input logic [1:0] b, input logic [3:0] i, input rgb12_t c);
        bus_if.wr_en    = 1'b1;
        bus_if.wr_bank  = b;
        bus_if.wr_index = i;
        bus_if.wr_rgb   = c;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic read_px(input string tag, input logic [1:0] b, input logic [3:0] i,
                           input logic t, input rgb12_t c);
        bus_if.pix_valid = 1'b1;
        bus_if.bank_sel  = b;
        bus_if.index     = i;
        @(negedge clk);
        bus_if.pix_valid = 1'b0;
        @(negedge clk);
        chk(tag, px_word(), exp_word(1'b1, t, c));
    endtask

    // Counts rising edges from reset release until init_done is seen high.
    task automatic wait_init(input string tag);
        int   n = 0;
        logic ovs = 1'b0;
        while (!bus_if.init_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_if.out_valid) ovs = 1'b1;
            if (n == 60) bus_if.wr_en = 1'b0;
        end
        @(negedge clk);
        chk(tag, 32'(n), 32'd65);
        chk({tag, "_ov"}, {31'd0, ovs}, 32'd0);
    endtask

    // Back-to-back pixels, one per clock; each result is checked two cycles later.
    task automatic stream(input string tag, input int n, input bit rnd);
        logic [1:0]  qb [$];
        logic [3:0]  qi [$];
        logic [1:0]  b;
        logic [3:0]  ix;
        logic [31:0] r;
        rgb12_t      ec;
        for (int k = 0; k < n + 2; k++) begin
            if (k >= 2) begin
                b  = qb.pop_front();
                ix = qi.pop_front();
                ec = (ix == 4'd0) ? 12'h000 : DEFAULT_PALETTE[b][ix];
                chk(tag, px_word(), exp_word(1'b1, ix == 4'd0, ec));
            end
            if (k < n) begin
                r  = rnd ? $urandom() : 32'(k);
                b  = r[5:4];
                ix = r[3:0];
                qb.push_back(b);
                qi.push_back(ix);
                bus_if.pix_valid = 1'b1;
                bus_if.bank_sel  = b;
                bus_if.index     = ix;
            end else begin
                bus_if.pix_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic ovs;
        bus_if.frame_tick  = 1'b0;
        bus_if.pix_valid   = 1'b0;
        bus_if.bank_sel    = '0;
        bus_if.index       = '0;
        bus_if.wr_en       = 1'b0;
        bus_if.wr_bank     = '0;
        bus_if.wr_index    = '0;
        bus_if.wr_rgb      = '0;
        bus_if.flash_start = 1'b0;
        bus_if.fade_start  = 1'b0;
        bus_if.fade_clear  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out", px_word(), 32'd0);
        chk("rst_flags", flags(), 32'd0);
        rst = 1'b0;
        wait_init("init_cycles");

        stream("dflt_all", 64, 1'b0);

        write_px(2'd1, 4'd5, 12'h3A7);
        read_px("wr_rd", 2'd1, 4'd5, 1'b0, 12'h3A7);
        bus_if.wr_en     = 1'b1;
        bus_if.wr_bank   = 2'd1;
        bus_if.wr_index  = 4'd5;
        bus_if.wr_rgb    = 12'h123;
        bus_if.pix_valid = 1'b1;
        bus_if.bank_sel  = 2'd1;
        bus_if.index     = 4'd5;
        @(negedge clk);
        bus_if.wr_en     = 1'b0;
        bus_if.pix_valid = 1'b0;
        @(negedge clk);
        chk("collide_old", px_word(), exp_word(1'b1, 1'b0, 12'h3A7));
        read_px("collide_new", 2'd1, 4'd5, 1'b0, 12'h123);

        write_px(2'd2, 4'd3, 12'hF8C);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fade_l16_busy", flags(), 32'd2);
        tick(4);
        chk("fade_l12_busy", flags(), 32'd3);
        read_px("fade_l12", 2'd2, 4'd3, 1'b0, 12'hB69);
        tick(16);
        read_px("fade_l0", 2'd2, 4'd3, 1'b0, 12'h000);
        chk("fade_l0_busy", flags(), 32'd2);
        tick(1);
        read_px("fade_l0_hold", 2'd2, 4'd3, 1'b0, 12'h000);
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        read_px("fade_clear", 2'd2, 4'd3, 1'b0, 12'hF8C);
        ctl(1'b1, 1'b0, 1'b0, 1'b1);
        read_px("start_tick", 2'd2, 4'd3, 1'b0, 12'hF8C);
        tick(1);
        read_px("fade_l15", 2'd2, 4'd3, 1'b0, 12'hE7B);
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        read_px("clear_prio", 2'd2, 4'd3, 1'b0, 12'hF8C);

        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        read_px("flash_c8", 2'd2, 4'd3, 1'b0, 12'hF8C);
        tick(1);
        read_px("flash_c7", 2'd2, 4'd3, 1'b0, 12'hFFF);
        read_px("flash_transp", 2'd2, 4'd0, 1'b1, 12'h000);
        tick(1);
        read_px("flash_c6", 2'd2, 4'd3, 1'b0, 12'hF8C);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        read_px("flash_over_fade", 2'd2, 4'd3, 1'b0, 12'hFFF);
        tick(1);
        read_px("fade_l14", 2'd2, 4'd3, 1'b0, 12'hD7A);
        tick(4);
        read_px("flash_end_l10", 2'd2, 4'd3, 1'b0, 12'h957);
        tick(1);
        read_px("flash_sat_l9", 2'd2, 4'd3, 1'b0, 12'h846);
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        tick(3);
        read_px("flash_c5", 2'd2, 4'd3, 1'b0, 12'hFFF);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        read_px("retrigger", 2'd2, 4'd3, 1'b0, 12'hF8C);
        tick(1);
        read_px("retrig_c7", 2'd2, 4'd3, 1'b0, 12'hFFF);
        tick(7);
        read_px("flash_done", 2'd2, 4'd3, 1'b0, 12'hF8C);

        repeat (3) @(negedge clk);
        chk("idle_out", px_word(), 32'd0);

        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        chk("midfade_busy", flags(), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midfade_flags", flags(), 32'd0);
        chk("midfade_out", px_word(), 32'd0);
        rst = 1'b0;
        bus_if.pix_valid = 1'b1;
        bus_if.bank_sel  = 2'd0;
        bus_if.index     = 4'd1;
        bus_if.wr_en     = 1'b1;
        bus_if.wr_bank   = 2'd0;
        bus_if.wr_index  = 4'd1;
        bus_if.wr_rgb    = 12'hABC;
        ovs = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.out_valid) ovs = 1'b1;
        end
        chk("midinit_ov", {31'd0, ovs}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midinit_flags", flags(), 32'd0);
        rst = 1'b0;
        wait_init("reinit_cycles");
        bus_if.pix_valid = 1'b0;
        bus_if.wr_en     = 1'b0;
        repeat (3) @(negedge clk);
        read_px("reload_b1i5", 2'd1, 4'd5, 1'b0, 12'h420);
        read_px("reload_l16", 2'd2, 4'd3, 1'b0, 12'hCCC);
        read_px("init_wr_drop", 2'd0, 4'd1, 1'b0, 12'hFFF);

        stream("rand_b2b", 40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
